// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: scan bus in, decoded display frame and status out
interface seg_scan_capture_if;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  err_mask;
  logic        frame_valid;
  logic        enable_err;
  logic        scan_stall;
  modport master (output seg_en, seg_out, input digits, dp_mask, err_mask, frame_valid, enable_err, scan_stall);
  modport slave  (input seg_en, seg_out, output digits, dp_mask, err_mask, frame_valid, enable_err, scan_stall);
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: follows a 7-segment scan, captures settled digits and assembles BCD frames
module seg_scan_capture #(
  parameter int          STABLE_CYCLES = 16,
  parameter int          STALL_CYCLES  = 200000,
  parameter logic [7:0]  DIGIT_MASK    = 8'h3F
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_en, r_seg;
  logic [15:0] r_prev;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_stall;
  logic [7:0]  r_seen;
  logic [31:0] r_stage_d;
  logic [7:0]  r_stage_dp, r_stage_err;
  logic        r_cap_d;
  logic [31:0] r_digits;
  logic [7:0]  r_dp, r_err;
  logic        r_fv, r_enable_err;
  logic        w_chg, w_onehot, w_multi, w_cap, w_done, w_bad;
  logic [2:0]  w_pos;
  logic [3:0]  w_nib;
  logic [6:0]  w_pat;
  logic [7:0]  w_bit;
  assign w_chg    = {r_en, r_seg} != r_prev;
  assign w_onehot = $onehot(~r_en);
  assign w_multi  = !$onehot0(~r_en);
  assign w_pat    = ~r_seg[6:0];
  assign w_bit    = 8'(1) << w_pos;
  assign w_done   = r_cap_d && ((r_seen & DIGIT_MASK) == DIGIT_MASK);
  // Sample the scan bus once; decisions compare this sample with the one before it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en   <= 8'hFF;
      r_seg  <= 8'hFF;
      r_prev <= 16'hFFFF;
    end else begin
      r_en   <= bus.seg_en;
      r_seg  <= bus.seg_out;
      r_prev <= {r_en, r_seg};
    end
  end
  // FSM state register
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  // FSM next state: any change restarts settling, a full stable dwell captures once
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_onehot ? SETTLE : IDLE;
      SETTLE:  w_next = w_chg ? (w_onehot ? SETTLE : IDLE) : (r_cnt == CW'(STABLE_CYCLES - 1) ? HELD : SETTLE);
      HELD:    w_next = w_chg ? (w_onehot ? SETTLE : IDLE) : HELD;
      default: w_next = IDLE;
    endcase
  end
  // FSM outputs: capture strobe, scanned position and segment decode
  always_comb begin
    w_cap = r_state == SETTLE && !w_chg && r_cnt == CW'(STABLE_CYCLES - 1);
    w_pos = '0;
    for (int k = 0; k < 8; k++) if (!r_en[k]) w_pos = 3'(k);
    case (w_pat)
      7'h3F:   w_nib = 4'd0;
      7'h06:   w_nib = 4'd1;
      7'h5B:   w_nib = 4'd2;
      7'h4F:   w_nib = 4'd3;
      7'h66:   w_nib = 4'd4;
      7'h6D:   w_nib = 4'd5;
      7'h7D:   w_nib = 4'd6;
      7'h07:   w_nib = 4'd7;
      7'h7F:   w_nib = 4'd8;
      7'h6F:   w_nib = 4'd9;
      default: w_nib = 4'hF;
    endcase
    w_bad = w_nib == 4'hF && w_pat != 7'h00;
  end
  // Stability counter runs only while settling on an unchanged sample
  always_ff @(posedge clk) r_cnt <= (rst_n && r_state == SETTLE && !w_chg && !w_cap) ? r_cnt + 1'b1 : '0;
  // Staging buffer: newest capture of each position wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_d   <= 32'hFFFF_FFFF;
      r_stage_dp  <= '0;
      r_stage_err <= '0;
    end else if (w_cap) begin
      r_stage_d[{w_pos, 2'b00} +: 4] <= w_nib;
      r_stage_dp[w_pos]              <= ~r_seg[7];
      r_stage_err[w_pos]             <= w_bad;
    end
  end
  // Frame assembly: publish staging once every masked position has been seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen   <= '0;
      r_cap_d  <= 1'b0;
      r_fv     <= 1'b0;
      r_digits <= 32'hFFFF_FFFF;
      r_dp     <= '0;
      r_err    <= '0;
    end else begin
      r_cap_d  <= w_cap;
      r_fv     <= w_done;
      r_seen   <= (w_done ? 8'h00 : r_seen) | (w_cap ? w_bit : 8'h00);
      r_digits <= w_done ? r_stage_d : r_digits;
      r_dp     <= w_done ? r_stage_dp : r_dp;
      r_err    <= w_done ? r_stage_err : r_err;
    end
  end
  // Sticky flag for more than one digit enabled at once
  always_ff @(posedge clk) r_enable_err <= rst_n && (r_enable_err || w_multi);
  // Stall timer: saturating count of cycles since the last capture
  always_ff @(posedge clk) r_stall <= (!rst_n || w_cap) ? '0 : (r_stall == SW'(STALL_CYCLES) ? r_stall : r_stall + 1'b1);
  assign bus.digits      = r_digits;
  assign bus.dp_mask     = r_dp;
  assign bus.err_mask    = r_err;
  assign bus.frame_valid = r_fv;
  assign bus.enable_err  = r_enable_err;
  assign bus.scan_stall  = r_stall == SW'(STALL_CYCLES);
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: dwell-level reference model checks every cycle of directed and random scans
module tb_seg_scan_capture;
  localparam int         STABLE = 16;
  localparam int         STALL  = 1000;
  localparam logic [7:0] MASK   = 8'h3F;
  localparam int         NEVER  = 32'h7FFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg_scan_capture_if bus();
  seg_scan_capture #(.STABLE_CYCLES(STABLE), .STALL_CYCLES(STALL), .DIGIT_MASK(MASK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int at; logic [31:0] d; logic [7:0] dp; logic [7:0] err;} frame_t;
  frame_t     fq[$];
  int         cq[$];
  int         n = 0, base = 0, err_at = NEVER, n_chk = 0, n_fail = 0;
  bit         live = 0, prev_rst = 0;
  logic [3:0] st_d[8];
  logic [7:0] st_dp, st_err, seen;
  logic [31:0] m_d;
  logic [7:0] m_dp, m_err, last_en = 8'hFF, last_so = 8'hFF;
  logic [6:0] font[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  // 0..9 digit, 10 blank, 11 illegal
  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (font[i] == p) return i;
    return p == 7'h00 ? 10 : 11;
  endfunction
  function automatic logic [7:0] pat(input int v, input bit dp);
    logic [6:0] f;
    f = v < 10 ? font[v] : 7'h00;
    return ~{dp, f};
  endfunction
  function automatic logic [7:0] en_of(input int p);
    return ~(8'(1) << p);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at step %0d", tag, got, exp, n);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) st_d[i] = 4'hF;
    st_dp = '0; st_err = '0; seen = '0;
    m_d = 32'hFFFF_FFFF; m_dp = '0; m_err = '0;
    fq.delete(); cq.delete();
    err_at = NEVER;
  endtask
  // One cycle: check what the previous edge produced, then drive the next edge's inputs
  task automatic step(input bit r, input logic [7:0] en, input logic [7:0] so);
    bit fv_exp;
    @(negedge clk);
    n++;
    if (prev_rst) begin
      model_reset();
      base = n - 1;
      live = 1;
    end
    while (cq.size() > 0 && cq[0] <= n - 1) base = cq.pop_front();
    if (live) begin
      fv_exp = fq.size() > 0 && fq[0].at == n;
      if (fv_exp) begin
        m_d = fq[0].d; m_dp = fq[0].dp; m_err = fq[0].err;
        fq.delete(0);
      end
      chk("frame_valid", 32'(bus.frame_valid), 32'(fv_exp));
      chk("digits", bus.digits, m_d);
      chk("dp_mask", 32'(bus.dp_mask), 32'(m_dp));
      chk("err_mask", 32'(bus.err_mask), 32'(m_err));
      chk("enable_err", 32'(bus.enable_err), 32'(n >= err_at));
      chk("scan_stall", 32'(bus.scan_stall), 32'((n - 1 - base) >= STALL));
    end
    rst_n = r; bus.seg_en = en; bus.seg_out = so;
    prev_rst = !r;
    if (r && !$onehot0(~en) && err_at > n + 2) err_at = n + 2;
  endtask
  // A dwell held long enough is captured STABLE+1 edges after it starts; a completing capture
  // publishes its frame one edge later, seen at the following sample step
  task automatic dwell(input logic [7:0] en, input logic [7:0] so, input int len);
    int s, p, c, dv;
    frame_t f;
    s = n + 1;
    if ($onehot(~en) && len >= STABLE + 1) begin
      p = 0;
      for (int i = 0; i < 8; i++) if (!en[i]) p = i;
      c = s + STABLE + 1;
      dv = decode(~so[6:0]);
      cq.push_back(c);
      st_d[p] = dv < 10 ? 4'(dv) : 4'hF;
      st_dp[p] = ~so[7];
      st_err[p] = dv == 11;
      seen[p] = 1'b1;
      if ((seen & MASK) == MASK) begin
        f.at = c + 2;
        for (int i = 0; i < 8; i++) f.d[i*4 +: 4] = st_d[i];
        f.dp = st_dp; f.err = st_err;
        fq.push_back(f);
        seen = '0;
      end
    end
    repeat (len) step(1'b1, en, so);
    last_en = en; last_so = so;
  endtask
  task automatic do_reset(input int k);
    repeat (4) step(1'b1, 8'hFF, 8'hFF);
    repeat (k) step(1'b0, 8'hFF, 8'hFF);
    step(1'b1, 8'hFF, 8'hFF);
    last_en = 8'hFF; last_so = 8'hFF;
  endtask
  task automatic clock_scan(input int p3v);
    for (int p = 0; p < 6; p++) dwell(en_of(p), p == 3 ? p3v[7:0] : pat(6 - p, p == 2 || p == 4), 40);
  endtask
  initial begin
    bus.seg_en = 8'hFF; bus.seg_out = 8'hFF;
    do_reset(3);
    chk("rst_digits", bus.digits, 32'hFFFF_FFFF);
    chk("rst_flags", {bus.frame_valid, bus.enable_err, bus.scan_stall, bus.dp_mask, bus.err_mask}, 0);
    clock_scan(pat(3, 0));
    clock_scan(pat(3, 0));
    dwell(8'hFF, 8'hFF, 5);
    chk("hhmmss", bus.digits[23:0], 24'h123456);
    chk("hhmmss_err", bus.err_mask, 0);
    for (int p = 0; p < 6; p++)
      if (p == 2) begin
        dwell(en_of(2), pat(7, 0), 10);
        dwell(en_of(2), pat(8, 0), 10);
        dwell(en_of(2), pat(9, 1), 10);
        dwell(en_of(2), pat(4, 0), 20);
      end else dwell(en_of(p), pat(6 - p, 0), 40);
    dwell(8'hFF, 8'hFF, 5);
    chk("glitch_final", bus.digits[11:8], 4);
    clock_scan(~8'h49);
    dwell(8'hFF, 8'hFF, 5);
    chk("illegal_err", bus.err_mask, 8'h08);
    chk("illegal_nib", bus.digits[23:0], 24'h12F456);
    for (int p = 0; p < 3; p++) dwell(en_of(p), pat(p + 7, 0), 40);
    do_reset(2);
    for (int p = 3; p < 6; p++) dwell(en_of(p), pat(p, 0), 40);
    dwell(8'hFF, 8'hFF, 5);
    chk("partial_no_frame", bus.digits, 32'hFFFF_FFFF);
    clock_scan(pat(3, 0));
    dwell(8'hFF, 8'hFF, STALL + 20);
    chk("stall_set", bus.scan_stall, 1);
    dwell(en_of(0), pat(1, 0), 17);
    dwell(en_of(1), pat(2, 0), 16);
    dwell(8'hFF, 8'hFF, 3);
    chk("stall_clear", bus.scan_stall, 0);
    dwell(8'b1111_1100, 8'hFF, 1);
    dwell(8'hFF, 8'hFF, 3);
    chk("enable_err_set", bus.enable_err, 1);
    for (int i = 0; i < 150; i++) begin
      int kind, p, len;
      logic [7:0] en, so;
      kind = $urandom_range(0, 99);
      p = $urandom_range(0, 7);
      en = en_of(p);
      so = pat($urandom_range(0, 10), $urandom_range(0, 1) == 1);
      len = $urandom_range(STABLE + 1, 40);
      if (kind >= 60 && kind < 70) begin
        so[6:0] = ~7'($urandom);
        while (decode(~so[6:0]) != 11) so[6:0] = ~7'($urandom);
      end else if (kind < 85 && kind >= 70) len = $urandom_range(1, STABLE);
      else if (kind < 92 && kind >= 85) begin
        en = 8'hFF;
        len = $urandom_range(1, 30);
      end else if (kind < 95 && kind >= 92) begin
        en = en & en_of((p + 1 + $urandom_range(0, 6)) % 8);
        len = $urandom_range(1, 5);
      end else if (kind >= 95) len = $urandom_range(STABLE, STABLE + 1);
      if ({en, so} == {last_en, last_so}) so[7] = ~so[7];
      dwell(en, so, len);
    end
    dwell(8'hFF, 8'hFF, 30);
    chk("frames_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
